// File: rtl/msg_block_arbiter_if.sv
// Bundle of requester-side and byte-stream signals for msg_block_arbiter.
// master: the arbiter. slave: requesters plus the downstream byte consumer.
interface msg_block_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int MSG_W = 448
);
    logic [NREQ-1:0]       req;
    logic [NREQ*MSG_W-1:0] msg_flat;
    logic [NREQ*6-1:0]     len_flat;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [7:0]            byte_out;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  blk_start;
    logic                  blk_last;
    logic                  len_err;
    logic                  busy;

    modport master (
        input  req, msg_flat, len_flat, byte_ready,
        output grant, done, byte_out, byte_valid, blk_start, blk_last, len_err, busy
    );

    modport slave (
        output req, msg_flat, len_flat, byte_ready,
        input  grant, done, byte_out, byte_valid, blk_start, blk_last, len_err, busy
    );
endinterface

// File: rtl/msg_block_arbiter.sv
// Round-robin arbiter that latches one requester's message and streams it
// as a single padded 64-byte SHA-256 block, one byte per handshake.
module msg_block_arbiter #(
    parameter int NREQ  = 4,
    parameter int MSG_W = 448
) (
    input  logic              clk,
    input  logic              rst,
    msg_block_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [MSG_W-1:0] msg_q;
    logic [5:0]       len_q;
    logic [5:0]       idx;

    logic [PW-1:0]    sel;
    logic [MSG_W-1:0] msg_sel;
    logic [5:0]       len_sel;
    logic [5:0]       len_clip;

    // Padded block byte k for message m of length l (l already clipped to 55).
    function automatic logic [7:0] blk_byte(input logic [MSG_W-1:0] m,
                                            input logic [5:0] l,
                                            input logic [5:0] k);
        logic [MSG_W-1:0] sh;
        logic [8:0]       bits;
        bits     = {l, 3'b000};
        sh       = m << (8 * int'(k));
        blk_byte = 8'h00;
        if (k < l)
            blk_byte = sh[MSG_W-1 -: 8];
        else if (k == l)
            blk_byte = 8'h80;
        else if (k == 6'd62)
            blk_byte = {7'b0, bits[8]};
        else if (k == 6'd63)
            blk_byte = bits[7:0];
    endfunction

    // Winner search: lowest offset from ptr with wrap-around wins.
    always_comb begin
        sel = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (bus.req[(int'(ptr) + o) % NREQ])
                sel = PW'((int'(ptr) + o) % NREQ);
        end
        msg_sel  = bus.msg_flat[int'(sel)*MSG_W +: MSG_W];
        len_sel  = bus.len_flat[int'(sel)*6 +: 6];
        len_clip = (len_sel > 6'd55) ? 6'd55 : len_sel;
    end

    // Control FSM; every output is registered and precomputed for the next byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            win            <= '0;
            msg_q          <= '0;
            len_q          <= '0;
            idx            <= '0;
            bus.grant      <= '0;
            bus.done       <= '0;
            bus.byte_out   <= '0;
            bus.byte_valid <= 1'b0;
            bus.blk_start  <= 1'b0;
            bus.blk_last   <= 1'b0;
            bus.len_err    <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        win            <= sel;
                        msg_q          <= msg_sel;
                        len_q          <= len_clip;
                        idx            <= '0;
                        bus.len_err    <= (len_sel > 6'd55);
                        bus.grant      <= NREQ'(1) << sel;
                        bus.byte_out   <= blk_byte(msg_sel, len_clip, 6'd0);
                        bus.byte_valid <= 1'b1;
                        bus.blk_start  <= 1'b1;
                        bus.blk_last   <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.byte_ready) begin
                        if (idx == 6'd63) begin
                            bus.done       <= bus.grant;
                            bus.grant      <= '0;
                            bus.byte_valid <= 1'b0;
                            bus.byte_out   <= '0;
                            bus.blk_last   <= 1'b0;
                            state          <= DONE;
                        end else begin
                            idx           <= idx + 6'd1;
                            bus.byte_out  <= blk_byte(msg_q, len_q, idx + 6'd1);
                            bus.blk_start <= 1'b0;
                            bus.blk_last  <= (idx == 6'd62);
                        end
                    end
                end
                DONE: begin
                    bus.done    <= '0;
                    bus.len_err <= 1'b0;
                    bus.busy    <= 1'b0;
                    ptr         <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_block_arbiter.sv
// Directed bench for msg_block_arbiter: single blocks, length corners,
// round-robin order, stalled downstream and mid-block reset.
module tb_msg_block_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [447:0] msgs [4];
    int           lens [4];
    logic [7:0]   cap  [64];
    logic [15:0]  pat;

    msg_block_arbiter_if #(.NREQ(4), .MSG_W(448)) bus ();

    msg_block_arbiter #(.NREQ(4), .MSG_W(448)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference padded block, written straight from the block layout rules.
    function automatic logic [7:0] exp_byte(input logic [447:0] m, input int len, input int k);
        int           l;
        logic [447:0] t;
        logic [15:0]  b;
        l = (len > 55) ? 55 : len;
        b = 16'(l * 8);
        if (k < l) begin
            t = m << (8 * k);
            return t[447:440];
        end
        if (k == l)  return 8'h80;
        if (k == 62) return b[15:8];
        if (k == 63) return b[7:0];
        return 8'h00;
    endfunction

    task automatic set_src(input int i, input logic [447:0] m, input int len);
        msgs[i] = m;
        lens[i] = len;
        bus.msg_flat[i*448 +: 448] = m;
        bus.len_flat[i*6 +: 6]     = 6'(len);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 64'(bus.grant), 64'(0));
        chk({tag, "_done"},  64'(bus.done), 64'(0));
        chk({tag, "_vld"},   64'(bus.byte_valid), 64'(0));
        chk({tag, "_byte"},  64'(bus.byte_out), 64'(0));
        chk({tag, "_start"}, 64'(bus.blk_start), 64'(0));
        chk({tag, "_last"},  64'(bus.blk_last), 64'(0));
        chk({tag, "_lerr"},  64'(bus.len_err), 64'(0));
        chk({tag, "_busy"},  64'(bus.busy), 64'(0));
    endtask

    // Called at a negedge; raises rq, expects requester w to be served next.
    task automatic run_block(input string tag, input logic [3:0] rq, input int w, input bit stall);
        int   k;
        int   cyc;
        logic experr;
        logic [3:0] oh;
        experr = (lens[w] > 55);
        oh     = 4'(1 << w);
        bus.req = bus.req | rq;
        k   = 0;
        cyc = 0;
        while (k < 64 && cyc < 400) begin
            @(negedge clk);
            chk({tag, "_vld"},   64'(bus.byte_valid), 64'(1));
            chk({tag, "_grant"}, 64'(bus.grant), 64'(oh));
            chk({tag, "_busy"},  64'(bus.busy), 64'(1));
            chk({tag, "_done"},  64'(bus.done), 64'(0));
            chk({tag, "_lerr"},  64'(bus.len_err), 64'(experr));
            chk({tag, "_byte"},  64'(bus.byte_out), 64'(exp_byte(msgs[w], lens[w], k)));
            chk({tag, "_start"}, 64'(bus.blk_start), 64'(k == 0));
            chk({tag, "_last"},  64'(bus.blk_last), 64'(k == 63));
            cap[k] = bus.byte_out;
            bus.byte_ready = stall ? pat[cyc % 16] : 1'b1;
            if (bus.byte_ready) k++;
            cyc++;
        end
        if (k < 64) chk({tag, "_timeout"}, 64'(k), 64'(64));
        @(negedge clk);
        chk({tag, "_dn_done"},  64'(bus.done), 64'(oh));
        chk({tag, "_dn_grant"}, 64'(bus.grant), 64'(0));
        chk({tag, "_dn_vld"},   64'(bus.byte_valid), 64'(0));
        chk({tag, "_dn_busy"},  64'(bus.busy), 64'(1));
        chk({tag, "_dn_lerr"},  64'(bus.len_err), 64'(experr));
        bus.req[w]     = 1'b0;
        bus.byte_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_idle_lerr"}, 64'(bus.len_err), 64'(0));
        chk({tag, "_idle_vld"},  64'(bus.byte_valid), 64'(0));
    endtask

    initial begin
        logic [447:0] m;
        errors = 0;
        checks = 0;
        pat    = 16'b1001_1010_0110_1001;
        rst    = 1'b1;
        bus.req        = '0;
        bus.msg_flat   = '0;
        bus.len_flat   = '0;
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            msgs[i] = '0;
            lens[i] = 0;
        end

        // Reset state, then idle with no requests.
        repeat (2) @(negedge clk);
        chk_idle("rst");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle("idle");

        // "abc" from requester 0.
        m = '0;
        m[447:424] = 24'h616263;
        set_src(0, m, 3);
        run_block("abc", 4'b0001, 0, 1'b0);
        chk("abc_b0",  64'(cap[0]),  64'(8'h61));
        chk("abc_b2",  64'(cap[2]),  64'(8'h63));
        chk("abc_b3",  64'(cap[3]),  64'(8'h80));
        chk("abc_b4",  64'(cap[4]),  64'(8'h00));
        chk("abc_b62", 64'(cap[62]), 64'(8'h00));
        chk("abc_b63", 64'(cap[63]), 64'(8'h18));

        // Zero length: only the 0x80 marker and a zero length field.
        set_src(1, {56{8'hA5}}, 0);
        run_block("len0", 4'b0010, 1, 1'b0);
        chk("len0_b0",  64'(cap[0]),  64'(8'h80));
        chk("len0_b1",  64'(cap[1]),  64'(8'h00));
        chk("len0_b63", 64'(cap[63]), 64'(8'h00));

        // Maximum length 55.
        m = {56{8'h3C}};
        m[7:0] = 8'hEE;
        set_src(2, m, 55);
        run_block("len55", 4'b0100, 2, 1'b0);
        chk("len55_b54", 64'(cap[54]), 64'(8'h3C));
        chk("len55_b55", 64'(cap[55]), 64'(8'h80));
        chk("len55_b62", 64'(cap[62]), 64'(8'h01));
        chk("len55_b63", 64'(cap[63]), 64'(8'hB8));

        // Oversize length 60 is clipped to 55 and flags len_err.
        set_src(3, m, 60);
        run_block("len60", 4'b1000, 3, 1'b0);
        chk("len60_b55", 64'(cap[55]), 64'(8'h80));
        chk("len60_b62", 64'(cap[62]), 64'(8'h01));
        chk("len60_b63", 64'(cap[63]), 64'(8'hB8));

        // Round robin: ptr=0 with req 0 and 2, then ptr=3 with req 0 and 1.
        set_src(0, {14{32'h1234_5678}}, 10);
        set_src(1, {14{32'h9ABC_DEF0}}, 17);
        set_src(2, {14{32'h0F1E_2D3C}}, 31);
        set_src(3, {14{32'hCAFE_F00D}}, 20);
        run_block("rr_a0", 4'b0101, 0, 1'b0);
        run_block("rr_a2", 4'b0000, 2, 1'b0);
        run_block("rr_b0", 4'b0011, 0, 1'b0);
        run_block("rr_b1", 4'b0000, 1, 1'b0);

        // Stalled downstream: ptr=2, requester 3 only.
        run_block("stall", 4'b1000, 3, 1'b1);

        // Mid-block reset during byte 20 of requester 1's block.
        bus.req[1]     = 1'b1;
        bus.byte_ready = 1'b1;
        repeat (21) @(negedge clk);
        chk("mid_b20",  64'(bus.byte_out), 64'(exp_byte(msgs[1], lens[1], 20)));
        chk("mid_busy", 64'(bus.busy), 64'(1));
        #2 rst = 1'b1;
        #1 chk_idle("arst");
        bus.byte_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_block("post_rst", 4'b0010, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/msg_block_arbiter.md
Name: msg_block_arbiter

Overview:
- Shares one SHA-256 message byte-stream path among NREQ requesters.
- Each requester presents a message of up to 55 bytes and its byte length.
- A round-robin arbiter selects one requester, latches its message and emits exactly one padded 64-byte SHA-256 block with a valid/ready handshake, then reports completion.
- Sits between the nonce/header sources and the SHA-256 message-schedule input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MSG_W, 448, message width per requester in bits; byte 0 = bits [MSG_W-1:MSG_W-8].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- msg_flat  in  NREQ*MSG_W  concatenated messages; requester i at [(i+1)*MSG_W-1 : i*MSG_W].
- len_flat  in  NREQ*6  concatenated byte lengths; requester i at [(i+1)*6-1 : i*6].
- grant  out  NREQ  one-hot; indicates the requester whose block is being streamed.
- done  out  NREQ  one-cycle pulse to the served requester after its last byte.
- byte_out  out  8  current block byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  downstream accepts the byte on clk when byte_valid&byte_ready.
- blk_start  out  1  high while byte index 0 is presented.
- blk_last  out  1  high while byte index 63 is presented.
- len_err  out  1  high for the whole block if the latched length was greater than 55.
- busy  out  1  high in STREAM and DONE.

Behaviour:
- Reset (async, immediate): state=IDLE; grant=0, done=0, byte_out=0, byte_valid=0, blk_start=0, blk_last=0, len_err=0, busy=0; rr pointer=0; byte index=0.
- States: IDLE, STREAM, DONE. All outputs are registered.
- IDLE, any req bit high at a clk edge:
  - Winner = first requester with req high, searching from ptr upward with wrap-around.
  - Latch winner's message and length. If length > 55, latch 55 and set len_err.
  - grant[winner]=1, idx=0, go to STREAM.
  - First byte_valid appears in the cycle after req is sampled (1-cycle latency).
- IDLE with req=0: remain in IDLE; all outputs low.
- Block byte k, with L = latched length:
  - k < L: message byte k.
  - k = L: 0x80.
  - L < k < 56: 0x00.
  - 56..63: 64-bit big-endian value L*8, so byte 62 = (L*8)>>8 and byte 63 = (L*8)&0xFF.
- STREAM:
  - byte_valid=1. byte_out, blk_start and blk_last hold stable while byte_ready=0.
  - idx advances only on a handshake.
  - Handshake at idx=63: byte_valid=0, grant=0, go to DONE.
- DONE:
  - done[winner]=1 for exactly one cycle.
  - ptr = (winner+1) mod NREQ.
  - len_err, busy clear on exit. Return to IDLE.
  - Next arbitration is sampled on the following edge, so the minimum gap between blocks is 2 idle byte slots.
- Requester inputs (req, msg, len) are ignored after latching. Deasserting req mid-block does not abort the block.
- Requester obligation: hold req until its done pulse, then drop req or present a new message.
- Simultaneous req from several requesters: only the winner is granted; the others wait.
- idx is 6 bits and never wraps inside a block; it returns to 0 only on the next grant.
- Reset mid-block: the block is abandoned with no done pulse. After reset release, arbitration restarts with ptr=0 and idx=0.

Test Plan:
1. req[0]=1, len=3, msg bytes 0x61 0x62 0x63, byte_ready=1 -> bytes 61 62 63 80, then 52×00, then 00 00 00 00 00 00 00 18. blk_start on byte 0, blk_last on byte 63, done[0] one-cycle pulse on the cycle after byte 63, grant[0] high for exactly 64 cycles.
2. len=0 -> byte0=0x80, bytes 1..63 = 0x00. len=55 -> byte55=0x80, byte62=0x01, byte63=0xB8, len_err=0.
3. len=60 -> treated as 55 (same bytes as the len=55 case), len_err=1 throughout the block, clear after done.
4. ptr=0, req[0] and req[2] high together -> block for 0 then block for 2 (ptr becomes 3). Then req[0] and req[1] high -> 0 served first (search order 3, 0).
5. byte_ready toggled 1,0,0,1 pseudo-randomly -> byte_out stable while stalled, no skipped or duplicated bytes, exactly 64 handshakes per block.
6. rst pulsed asynchronously at byte 20 (between clk edges) -> all outputs 0 immediately. After release with req[1] held -> fresh block from byte 0, no done pulse for the aborted block.
